kim_fifo_rr_arbiter: RTL and testbench
======================================

# kim_fifo_rr_arbiter

Packet-level round-robin arbiter that shares one FIFO write port among `NUM_REQ` valid/ready requesters. It sits directly in front of the FIFO slave side (`s_valid`/`s_ready`/`s_data`). It grants one requester at a time and holds the grant until that requester's `last` beat is accepted, so packets are never interleaved. The winner's index is forwarded alongside the data for downstream demux.

## Interface
- `NUM_REQ`, 4, number of requesters (2..16)
- `LOG2_REQ`, 2, width of requester index, ceil(log2(`NUM_REQ`))
- `DATA_LENGTH`, 32, data width per beat
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset; all state clears immediately on assertion, release synchronous to `clk`
- `req_valid`  in  `NUM_REQ`  per-requester beat valid
- `req_ready`  out  `NUM_REQ`  per-requester beat accepted (one-hot or zero)
- `req_data`  in  `NUM_REQ*DATA_LENGTH`  requester i occupies bits [i*DATA_LENGTH +: DATA_LENGTH]
- `req_last`  in  `NUM_REQ`  per-requester end-of-packet flag
- `m_valid`  out  1  to FIFO `s_valid`
- `m_ready`  in  1  from FIFO `s_ready`
- `m_data`  out  `DATA_LENGTH`  to FIFO `s_data`
- `m_last`  out  1  end-of-packet of granted requester
- `m_id`  out  `LOG2_REQ`  index of granted requester
- `busy`  out  1  high while a grant is held (S_LOCK)

## Operation
- States: S_IDLE (no grant), S_LOCK (grant held).
- Registers: `c_state`, `grant_id` (`LOG2_REQ`), `last_id` (`LOG2_REQ`, most recently served requester).
- S_IDLE:
  - Search `req_valid` starting at (`last_id`+1) mod `NUM_REQ`, wrapping.
  - First asserted index is loaded into `grant_id`; next state is S_LOCK.
  - If no request is asserted, stay in S_IDLE.
  - `m_valid`=0, `req_ready`=0.
- S_LOCK:
  - Combinational pass-through of the granted requester: `m_valid`=`req_valid[grant_id]`, `m_data`/`m_last` from slice `grant_id`.
  - `req_ready[grant_id]`=`m_ready`; all other `req_ready` bits are 0.
- Beat accepted when `m_valid && m_ready`.
- If the accepted beat has `m_last`=1:
  - `last_id` <= `grant_id`.
  - Next state is S_IDLE.
- Grant is never revoked mid-packet, whether the requester drops `req_valid` (bubble) or `m_ready` stays low (FIFO full). The arbiter waits indefinitely.
- Requests from non-granted requesters are ignored until the next S_IDLE; they are never acknowledged.
- Wrap: when `NUM_REQ` is not a power of two, index arithmetic is mod `NUM_REQ`. Indices >= `NUM_REQ` are never produced.
- `m_id`=`grant_id`; valid only while `busy`=1.
- Reset values:
  - `c_state`=S_IDLE, `grant_id`=0, `last_id`=`NUM_REQ`-1, so requester 0 has first priority.
  - Outputs: `m_valid`=0, `req_ready`=0, `busy`=0, `m_last`=0, `m_id`=0, `m_data`=0.
- Reset mid-packet: the grant is dropped immediately and the partial packet is abandoned. Upstream and FIFO flushing is the integrator's responsibility.

## Timing
- Arbitration latency: a request seen in S_IDLE at edge N is granted at edge N; its first beat can transfer in cycle N+1.
- One idle bubble after every packet: the cycle in S_IDLE following the `last` handshake.
- Single-beat packet (`req_last`=1 on first beat): occupies exactly 2 cycles (IDLE + LOCK) when `m_ready`=1.
- Sustained throughput with `m_ready`=1 and L-beat packets: L/(L+1).
- Data path is purely combinational: zero latency from `req_*` to `m_*` in S_LOCK. No registers on data.
- Rotation is updated only on the `last` handshake. A requester re-asserting in the same cycle it finishes loses to any other pending requester.

## Test plan
- Reset, then `req_valid`=4'b1111 with all packets 1 beat and `m_ready`=1 -> grant order 0,1,2,3,0; `m_id` changes every 2 cycles; `busy` toggles 0,1.
- Requester 2 sends a 3-beat packet (data 0xA0,0xA1,0xA2, last on beat 3) while requester 1 is continuously valid -> `m_data` sequence is A0,A1,A2 with `m_id`=2 throughout; requester 1 is granted only after `last`; `req_ready[1]`=0 during the packet.
- In S_LOCK, drop `m_ready` for 5 cycles mid-packet -> `m_valid`, `m_data`, `m_id` held; `req_ready[grant]`=0; grant unchanged; resumes on the same beat.
- Granted requester deasserts `req_valid` for 2 cycles mid-packet while others request -> `m_valid`=0, grant held, no other requester accepted.
- `NUM_REQ`=3, `last_id`=2, only requester 0 valid -> wrap search selects 0; `m_id` never reads 3.
- Assert `rst_n`=0 asynchronously mid-packet between clock edges -> `busy`, `m_valid`, `req_ready` go 0 immediately; after release, requester 0 wins first.

Source files
------------

// File: rtl/kim_fifo_rr_arbiter_if.sv
// Bundle of the requester-side and FIFO-side signals of the packet round-robin
// arbiter. The arbiter connects through the master modport. The requesters and
// the FIFO connect through the slave modport.
interface kim_fifo_rr_arbiter_if #(
    parameter int NUM_REQ     = 4,
    parameter int LOG2_REQ    = 2,
    parameter int DATA_LENGTH = 32
);
    logic [NUM_REQ-1:0]             req_valid;
    logic [NUM_REQ-1:0]             req_ready;
    logic [NUM_REQ*DATA_LENGTH-1:0] req_data;
    logic [NUM_REQ-1:0]             req_last;
    logic                           m_valid;
    logic                           m_ready;
    logic [DATA_LENGTH-1:0]         m_data;
    logic                           m_last;
    logic [LOG2_REQ-1:0]            m_id;
    logic                           busy;

    modport master (
        input  req_valid, req_data, req_last, m_ready,
        output req_ready, m_valid, m_data, m_last, m_id, busy
    );

    modport slave (
        output req_valid, req_data, req_last, m_ready,
        input  req_ready, m_valid, m_data, m_last, m_id, busy
    );
endinterface

// File: rtl/kim_fifo_rr_arbiter.sv
// Packet-level round-robin arbiter in front of a FIFO write port.
// In S_IDLE the arbiter picks the next requester after the one served last.
// It then locks onto that requester until its last beat is accepted, so that
// packets are never interleaved.
// The beat path is a combinational mux from the locked requester. The grant,
// the rotation pointer and the state are the only registers.
module kim_fifo_rr_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int LOG2_REQ    = 2,
    parameter int DATA_LENGTH = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    kim_fifo_rr_arbiter_if.master         bus
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_LOCK = 1'b1
    } state_e;

    // Requester 0 must be the first choice out of reset.
    localparam logic [LOG2_REQ-1:0] LAST_RST = LOG2_REQ'(NUM_REQ - 1);

    state_e                 c_state_q;
    logic [LOG2_REQ-1:0]    grant_id_q;
    logic [LOG2_REQ-1:0]    last_id_q;

    logic                   pick_hit_s;
    logic [LOG2_REQ-1:0]    pick_id_s;
    logic                   m_valid_s;
    logic                   m_last_s;
    logic [DATA_LENGTH-1:0] m_data_s;
    logic [NUM_REQ-1:0]     req_ready_s;

    // Searches the requesters for a winner, starting one past the last served
    // requester and wrapping mod NUM_REQ. The last served requester is checked
    // last. The offsets are scanned from the farthest to the nearest, so the
    // nearest asserted requester is the final value written and wins.
    // The MSB of the result is the hit flag.
    function automatic logic [LOG2_REQ:0] rr_search(
        input logic [NUM_REQ-1:0]  valid,
        input logic [LOG2_REQ-1:0] last
    );
        logic [LOG2_REQ:0]   res;
        logic [LOG2_REQ-1:0] idx_v;
        res = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx_v = LOG2_REQ'((int'(last) + k) % NUM_REQ);
            if (valid[idx_v]) begin
                res = {1'b1, idx_v};
            end
        end
        return res;
    endfunction

    // Selects the next winner from the current requests and the rotation pointer.
    always_comb begin
        pick_hit_s = 1'b0;
        pick_id_s  = '0;
        {pick_hit_s, pick_id_s} = rr_search(bus.req_valid, last_id_q);
    end

    // Passes the locked requester through to the FIFO and steers m_ready back to it.
    always_comb begin
        m_valid_s   = 1'b0;
        m_last_s    = 1'b0;
        m_data_s    = '0;
        req_ready_s = '0;
        if (c_state_q == S_LOCK) begin
            m_valid_s              = bus.req_valid[grant_id_q];
            m_last_s               = bus.req_last[grant_id_q];
            m_data_s               = bus.req_data[int'(grant_id_q)*DATA_LENGTH +: DATA_LENGTH];
            req_ready_s[grant_id_q] = bus.m_ready;
        end else begin
            m_valid_s   = 1'b0;
            m_last_s    = 1'b0;
            m_data_s    = '0;
            req_ready_s = '0;
        end
    end

    // The arbitration FSM grants in S_IDLE. It releases the grant and advances
    // the rotation only when the last beat of the packet is handed to the FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_state_q  <= S_IDLE;
            grant_id_q <= '0;
            last_id_q  <= LAST_RST;
        end else begin
            case (c_state_q)
                S_IDLE: begin
                    if (pick_hit_s) begin
                        grant_id_q <= pick_id_s;
                        c_state_q  <= S_LOCK;
                    end
                end
                S_LOCK: begin
                    if (m_valid_s && bus.m_ready && m_last_s) begin
                        last_id_q <= grant_id_q;
                        c_state_q <= S_IDLE;
                    end
                end
                default: begin
                    c_state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.m_valid   = m_valid_s;
    assign bus.m_last    = m_last_s;
    assign bus.m_data    = m_data_s;
    assign bus.req_ready = req_ready_s;
    assign bus.m_id      = grant_id_q;
    assign bus.busy      = (c_state_q == S_LOCK);

endmodule

// File: tb/tb_kim_fifo_rr_arbiter.sv
// Directed bench for the packet round-robin arbiter.
// A per-cycle reference model tracks the owner of the grant and the rotation
// pointer as plain integers. Directed phases check the accepted-beat log
// against literal sequences.
// A second instance with three requesters covers the wrap-around search.
module tb_kim_fifo_rr_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    kim_fifo_rr_arbiter_if #(.NUM_REQ(4), .LOG2_REQ(2), .DATA_LENGTH(32)) bus ();
    kim_fifo_rr_arbiter_if #(.NUM_REQ(3), .LOG2_REQ(2), .DATA_LENGTH(32)) bus2 ();

    kim_fifo_rr_arbiter #(.NUM_REQ(4), .LOG2_REQ(2), .DATA_LENGTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.master)
    );
    kim_fifo_rr_arbiter #(.NUM_REQ(3), .LOG2_REQ(2), .DATA_LENGTH(32)) dut3 (
        .clk(clk), .rst_n(rst_n), .bus(bus2.master)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- requester sources ----------------
    logic [32:0] mem [4][16];
    int          head [4];
    int          tail [4];
    logic [3:0]  en;

    int          log_id [$];
    logic [31:0] log_d [$];

    logic        snap_busy, snap_mv;
    logic [3:0]  snap_rdy;
    logic [1:0]  snap_mid;
    logic [31:0] snap_md;

    task automatic push(input int i, input logic [31:0] d, input logic l);
        mem[i][tail[i]] = {l, d};
        tail[i]++;
    endtask

    task automatic drive();
        for (int i = 0; i < 4; i++) begin
            if (head[i] < tail[i]) begin
                bus.req_valid[i]           = en[i];
                bus.req_data[i*32 +: 32]   = mem[i][head[i]][31:0];
                bus.req_last[i]            = mem[i][head[i]][32];
            end else begin
                bus.req_valid[i]           = 1'b0;
                bus.req_data[i*32 +: 32]   = 32'h0;
                bus.req_last[i]            = 1'b0;
            end
        end
    endtask

    // One clock cycle: observe at the falling edge, then advance the sources after the rising edge.
    task automatic step();
        logic [3:0] acc;
        @(negedge clk);
        acc       = bus.req_valid & bus.req_ready;
        snap_busy = bus.busy;
        snap_mv   = bus.m_valid;
        snap_rdy  = bus.req_ready;
        snap_mid  = bus.m_id;
        snap_md   = bus.m_data;
        if (bus.m_valid && bus.m_ready) begin
            log_id.push_back(int'(bus.m_id));
            log_d.push_back(bus.m_data);
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (acc[i]) head[i]++;
        end
        drive();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_log(input string nm, input int n, input int ids[5], input logic [31:0] ds[5]);
        chk({nm, "_count"}, 64'(log_id.size()), 64'(n));
        for (int i = 0; i < n; i++) begin
            chk({nm, "_id"},   (i < log_id.size()) ? 64'(log_id[i]) : 64'hFFFF, 64'(ids[i]));
            chk({nm, "_data"}, (i < log_d.size())  ? 64'(log_d[i])  : 64'hFFFF, 64'(ds[i]));
        end
        log_id.delete();
        log_d.delete();
    endtask

    // ---------------- reference model ----------------
    int own;
    int prev;

    function automatic int pick(input logic [3:0] v, input int p);
        for (int k = 1; k <= 4; k++) begin
            if (v[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    // The model owner takes a requester when it is free, and frees itself when the last beat is taken.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            own  <= -1;
            prev <= 3;
        end else if (own < 0) begin
            own <= pick(bus.req_valid, prev);
        end else if (bus.req_valid[own[1:0]] && bus.m_ready && bus.req_last[own[1:0]]) begin
            prev <= own;
            own  <= -1;
        end
    end

    // Per-cycle comparison of every DUT output against the model.
    always @(negedge clk) begin : cmp
        logic [3:0] er;
        if (!rst_n || own < 0) begin
            chk("cyc_busy",  64'(bus.busy), 64'd0);
            chk("cyc_mvalid", 64'(bus.m_valid), 64'd0);
            chk("cyc_ready", 64'(bus.req_ready), 64'd0);
            chk("cyc_mdata", 64'(bus.m_data), 64'd0);
            chk("cyc_mlast", 64'(bus.m_last), 64'd0);
            if (!rst_n) chk("cyc_mid_rst", 64'(bus.m_id), 64'd0);
        end else begin
            er = bus.m_ready ? (4'b0001 << own) : 4'b0000;
            chk("cyc_busy",   64'(bus.busy), 64'd1);
            chk("cyc_mid",    64'(bus.m_id), 64'(own));
            chk("cyc_mvalid", 64'(bus.m_valid), 64'(bus.req_valid[own[1:0]]));
            chk("cyc_ready",  64'(bus.req_ready), 64'(er));
            chk("cyc_mdata",  64'(bus.m_data), 64'(bus.req_data[own*32 +: 32]));
            chk("cyc_mlast",  64'(bus.m_last), 64'(bus.req_last[own[1:0]]));
        end
        chk("n3_mid_range", 64'(bus2.m_id < 2'd3), 64'd1);
    end

    // ---------------- directed sequence ----------------
    initial begin
        for (int i = 0; i < 4; i++) begin
            head[i] = 0;
            tail[i] = 0;
        end
        en             = 4'b1111;
        bus.m_ready    = 1'b1;
        bus.req_valid  = 4'b0000;
        bus.req_last   = 4'b0000;
        bus.req_data   = '0;
        bus2.m_ready   = 1'b1;
        bus2.req_valid = 3'b000;
        bus2.req_last  = 3'b111;
        bus2.req_data  = {32'h1002, 32'h1001, 32'h1000};

        // Test 1: all four requesters with single-beat packets; requester 0 has two.
        push(0, 32'h00, 1'b1); push(0, 32'h04, 1'b1);
        push(1, 32'h01, 1'b1); push(2, 32'h02, 1'b1); push(3, 32'h03, 1'b1);
        drive();
        #12;
        chk("rst_busy",   64'(bus.busy), 64'd0);
        chk("rst_mvalid", 64'(bus.m_valid), 64'd0);
        chk("rst_ready",  64'(bus.req_ready), 64'd0);
        chk("rst_mid",    64'(bus.m_id), 64'd0);
        chk("rst_mdata",  64'(bus.m_data), 64'd0);
        chk("rst_mlast",  64'(bus.m_last), 64'd0);
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            chk("t1_busy_toggle", 64'(snap_busy), 64'(k % 2));
        end
        check_log("t1", 5, '{0, 1, 2, 3, 0}, '{32'h00, 32'h01, 32'h02, 32'h03, 32'h04});

        // Test 2: a 3-beat packet from requester 2 holds off requester 1, which stays valid.
        push(1, 32'h11, 1'b1);
        drive();
        step(); step();
        log_id.delete(); log_d.delete();
        push(2, 32'hA0, 1'b0); push(2, 32'hA1, 1'b0); push(2, 32'hA2, 1'b1);
        push(1, 32'h12, 1'b1);
        drive();
        step();
        for (int k = 0; k < 3; k++) begin
            step();
            chk("t2_mid_locked", 64'(snap_mid), 64'd2);
            chk("t2_ready1_low", 64'(snap_rdy[1]), 64'd0);
        end
        step(); step();
        check_log("t2", 4, '{2, 2, 2, 1, 0}, '{32'hA0, 32'hA1, 32'hA2, 32'h12, 32'h0});

        // Test 3: the FIFO stalls for 5 cycles mid-packet while requester 0 waits.
        push(3, 32'hB0, 1'b0); push(3, 32'hB1, 1'b0); push(3, 32'hB2, 1'b1);
        push(0, 32'hC0, 1'b1);
        drive();
        step(); step();
        bus.m_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("t3_stall_mvalid", 64'(snap_mv), 64'd1);
            chk("t3_stall_mdata",  64'(snap_md), 64'hB1);
            chk("t3_stall_mid",    64'(snap_mid), 64'd3);
            chk("t3_stall_ready",  64'(snap_rdy), 64'd0);
        end
        bus.m_ready = 1'b1;
        step(); step(); step(); step();
        check_log("t3", 4, '{3, 3, 3, 0, 0}, '{32'hB0, 32'hB1, 32'hB2, 32'hC0, 32'h0});

        // Test 4: the granted requester inserts a 2-cycle bubble while requester 2 waits.
        push(1, 32'hD0, 1'b0); push(1, 32'hD1, 1'b0); push(1, 32'hD2, 1'b1);
        push(2, 32'hE0, 1'b1);
        drive();
        step(); step();
        en[1] = 1'b0;
        drive();
        for (int k = 0; k < 2; k++) begin
            step();
            chk("t4_bubble_mvalid", 64'(snap_mv), 64'd0);
            chk("t4_bubble_ready",  64'(snap_rdy), 64'b0010);
            chk("t4_bubble_mid",    64'(snap_mid), 64'd1);
            chk("t4_bubble_busy",   64'(snap_busy), 64'd1);
        end
        chk("t4_bubble_nolog", 64'(log_id.size()), 64'd1);
        en[1] = 1'b1;
        drive();
        step(); step(); step(); step();
        check_log("t4", 4, '{1, 1, 1, 2, 0}, '{32'hD0, 32'hD1, 32'hD2, 32'hE0, 32'h0});

        // Test 5: three requesters; the search wraps from index 2 back to 0.
        bus2.req_valid = 3'b001;
        @(negedge clk);
        chk("n3_idle0_busy", 64'(bus2.busy), 64'd0);
        tick(); @(negedge clk);
        chk("n3_g0_mid",   64'(bus2.m_id), 64'd0);
        chk("n3_g0_data",  64'(bus2.m_data), 64'h1000);
        chk("n3_g0_ready", 64'(bus2.req_ready), 64'b001);
        tick();
        bus2.req_valid = 3'b100;
        @(negedge clk);
        chk("n3_idle1_busy", 64'(bus2.busy), 64'd0);
        tick(); @(negedge clk);
        chk("n3_g2_mid",   64'(bus2.m_id), 64'd2);
        chk("n3_g2_data",  64'(bus2.m_data), 64'h1002);
        chk("n3_g2_ready", 64'(bus2.req_ready), 64'b100);
        tick();
        bus2.req_valid = 3'b001;
        @(negedge clk);
        chk("n3_idle2_busy", 64'(bus2.busy), 64'd0);
        tick(); @(negedge clk);
        chk("n3_wrap_mid",   64'(bus2.m_id), 64'd0);
        chk("n3_wrap_ready", 64'(bus2.req_ready), 64'b001);
        tick();
        bus2.req_valid = 3'b000;

        // Test 6: asynchronous reset mid-packet, then requester 0 wins first.
        push(3, 32'hF0, 1'b0); push(3, 32'hF1, 1'b0); push(3, 32'hF2, 1'b1);
        drive();
        step(); step();
        chk("t6_pre_busy", 64'(bus.busy), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_busy",   64'(bus.busy), 64'd0);
        chk("t6_async_mvalid", 64'(bus.m_valid), 64'd0);
        chk("t6_async_ready",  64'(bus.req_ready), 64'd0);
        tick();
        rst_n = 1'b1;
        head[3] = tail[3];
        log_id.delete(); log_d.delete();
        push(3, 32'h73, 1'b1); push(1, 32'h71, 1'b1); push(0, 32'h70, 1'b1);
        drive();
        for (int k = 0; k < 6; k++) step();
        check_log("t6", 3, '{0, 1, 3, 0, 0}, '{32'h70, 32'h71, 32'h73, 32'h0, 32'h0});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
